// File: rtl/pdm_speaker_if.sv
// Sample stream into the PDM speaker transmitter: signed PCM words with valid/ready flow control.
interface pdm_speaker_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pdm_speaker.sv
// First-order sigma-delta PDM transmitter: buffers one PCM sample ahead and emits one
// PDM bit per divided-clock tick, OSR bits per sample.
module pdm_speaker #(
   parameter int INPUT_FREQ = 100000000,
   parameter int PDM_FREQ   = 2400000,
   parameter int OSR        = 50,
   parameter int DATA_WIDTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   pdm_speaker_if.slave s,
   output logic         pdm_out,
   output logic         pdm_tick,
   output logic         underrun,
   output logic         AUD_SD
);
   localparam int W     = DATA_WIDTH;
   localparam int DIV   = INPUT_FREQ / PDM_FREQ;
   localparam int DIV_W = $clog2(DIV);
   localparam int OSR_W = $clog2(OSR);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [OSR_W-1:0] osr_cnt;
   logic [W-1:0]     acc;
   logic [W-1:0]     cur;
   logic [W-1:0]     nxt;
   logic             nxt_full;

   logic             tick;
   logic             boundary;
   logic             take;
   logic [W-1:0]     u;
   logic [W:0]       sum;

   assign s.ready  = !nxt_full;
   assign take     = s.valid && !nxt_full;
   assign tick     = enable && (div_cnt == DIV_LAST);
   assign boundary = tick && (osr_cnt == OSR_LAST);

   // Offset-binary view of the sample: the carry out of acc + u has ones density u / 2^W.
   assign u   = {~cur[W-1], cur[W-2:0]};
   assign sum = {1'b0, acc} + {1'b0, u};

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt  <= '0;
         osr_cnt  <= '0;
         acc      <= '0;
         cur      <= '0;
         nxt      <= '0;
         nxt_full <= 1'b0;
         pdm_out  <= 1'b0;
         pdm_tick <= 1'b0;
         underrun <= 1'b0;
         AUD_SD   <= 1'b0;
      end else begin
         AUD_SD   <= enable;
         pdm_tick <= tick;
         underrun <= boundary && !nxt_full && !take;

         // A word arriving exactly on an empty boundary bypasses the holding register.
         if (take && !boundary) begin
            nxt      <= s.data;
            nxt_full <= 1'b1;
         end

         if (!enable) begin
            div_cnt <= '0;
            osr_cnt <= '0;
            acc     <= '0;
            cur     <= '0;
            pdm_out <= 1'b0;
         end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
               osr_cnt <= (osr_cnt == OSR_LAST) ? '0 : osr_cnt + OSR_W'(1);
               acc     <= sum[W-1:0];
               pdm_out <= sum[W];
            end
            if (boundary) begin
               if (nxt_full) begin
                  cur      <= nxt;
                  nxt_full <= 1'b0;
               end else if (take) begin
                  cur <= s.data;
               end else begin
                  cur <= '0;
               end
            end
         end
      end
   end
endmodule

// File: doc/pdm_speaker.md
# pdm_speaker

PDM audio output transmitter: accepts signed PCM samples over a valid/ready stream, runs a first-order sigma-delta modulator and drives a 1-bit PDM stream to the board's audio amplifier/low-pass filter. It is the output-side counterpart of the PDM microphone capture path. It shares that path's clocking scheme: a bit-rate strobe derived from the system clock by integer division.

## Interface
- INPUT_FREQ, 100000000: system clock frequency in Hz.
- PDM_FREQ, 2400000: target PDM bit rate in Hz. DIV = INPUT_FREQ / PDM_FREQ (integer division, 41 for defaults). DIV ≥ 2 is required.
- OSR, 50: PDM bits per PCM sample. OSR ≥ 2.
- DATA_WIDTH, 16: PCM sample width W, two's complement.

- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  run modulator; 0 = idle/silent.
- s_data  in  W  signed PCM sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  block can accept a sample.
- pdm_out  out  1  PDM bit to amplifier.
- pdm_tick  out  1  one-cycle strobe, high in the cycle pdm_out takes a new value.
- underrun  out  1  one-cycle pulse: sample boundary reached with no sample buffered.
- AUD_SD  out  1  amplifier shutdown-bar; registered copy of enable.

## Operation
- Divider: counter div_cnt 0..DIV-1 increments every cycle while enable=1. Internal tick = (enable && div_cnt==DIV-1); div_cnt wraps to 0.
- Oversample counter osr_cnt 0..OSR-1 advances on each tick and wraps.
- Buffering: one-entry holding register nxt plus flag nxt_full. s_ready = !nxt_full. The handshake (s_valid && s_ready) writes nxt and sets nxt_full. Samples are accepted regardless of enable.
- Sample boundary = tick && osr_cnt==OSR-1. At a boundary:
  - if nxt_full: cur ← nxt, nxt_full ← 0.
  - else if a handshake occurs in the same cycle: cur ← s_data directly, no underrun, and nxt stays empty.
  - else: cur ← 0 (silence), underrun pulses for 1 cycle.
- Modulator, updated on tick only:
  - u = cur with MSB inverted (offset binary, W bits).
  - sum = {1'b0, acc} + u, a (W+1)-bit sum.
  - acc ← sum[W-1:0]; the PDM bit is sum[W].
  - Ones density = u / 2^W: s=0 → 1/2; max positive → (2^W−1)/2^W; most negative → 0.
- The modulator for a tick uses cur as it was before that tick. A sample loaded at a boundary is first used on the following tick.
- enable=0: div_cnt, osr_cnt and acc are held at 0; cur ← 0; pdm_out ← 0; no ticks and no underrun. nxt and nxt_full are retained. Re-enabling restarts from div_cnt=0.

## Timing
- Reset values: s_ready=1, pdm_out=0, pdm_tick=0, underrun=0, AUD_SD=0; internally div_cnt=osr_cnt=acc=cur=0, nxt_full=0.
- pdm_out and pdm_tick are registered and update on the clock edge after the internal tick. underrun is registered on the same edge. AUD_SD lags enable by 1 cycle.
- First pdm_tick occurs DIV cycles after the first cycle with enable=1 sampled high. Ticks then repeat every DIV cycles.
- Sample period = OSR·DIV clk cycles (2050 for defaults, about 48.78 kHz).
- s_ready falls the cycle after an accept and rises the cycle after the boundary that consumes nxt. Sustained throughput is one sample per sample period.
- rst mid-operation: all state returns to reset values on the next edge, and the buffered sample is discarded.
- rst has priority over every other event.

## Test plan
- Reset: assert rst for 3 cycles with enable=1 and s_valid=1 → s_ready=1, pdm_out=0, pdm_tick=0, underrun=0, AUD_SD=0, and no handshake is taken during reset.
- Zero signal (W=8, DIV=4, OSR=8), stream of 0x00 → pdm_out sequence 0,1,0,1,… with pdm_tick every 4 cycles; first pdm_tick exactly 4 cycles after enable rises.
- Full scale (W=8): feed 0x7F continuously → exactly 255 ones per 256 consecutive ticks once cur holds 0x7F. Feed 0x80 → pdm_out stays 0 for all ticks.
- Underrun: enable with no samples → underrun pulses once every 32 cycles (OSR·DIV), and pdm_out alternates 0,1. Supply one sample and confirm the next boundary has no underrun pulse.
- Backpressure: hold s_valid=1 with values 0x10, 0x20, 0x30 → 0x10 accepted immediately, s_ready low until the next boundary, each further word accepted in the cycle after a boundary, and no sample is lost or duplicated.
- Enable drop: deassert enable mid-sample with nxt_full=1 → pdm_out=0 next edge, ticks stop, AUD_SD=0 after 1 cycle. On re-enable the buffered sample is loaded at the first boundary, and acc restarts from 0.
